// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the Hi/Lo result path.
// Shift-add multiply and restoring divide on magnitudes, then a one-cycle sign fixup.
module hilo_muldiv_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  StartIn,
    input  logic [1:0]            OpIn,
    input  logic [DATA_W-1:0]     AIn,
    input  logic [DATA_W-1:0]     BIn,
    input  logic                  HiLoReadIn,
    output logic                  BusyOut,
    output logic                  StallOut,
    output logic                  DoneOut,
    output logic                  HiWriteOut,
    output logic                  LoWriteOut,
    output logic [2*DATA_W-1:0]   Result64Out
);

    localparam int unsigned RES_W = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [1:0]         opReg;
    logic               signA;
    logic               signB;
    logic [RES_W-1:0]   acc;
    logic [RES_W-1:0]   mcand;
    logic [DATA_W-1:0]  bReg;
    logic [DATA_W-1:0]  rem;
    logic [DATA_W-1:0]  quo;

    logic               aNeg;
    logic               bNeg;
    logic [DATA_W-1:0]  aMag;
    logic [DATA_W-1:0]  bMag;
    logic [DATA_W:0]    remShift;
    logic [DATA_W:0]    trial;
    logic               signDiff;
    logic               divZero;
    logic [RES_W-1:0]   prodFix;
    logic [DATA_W-1:0]  quoFix;
    logic [DATA_W-1:0]  remFix;
    logic [RES_W-1:0]   fixed;

    assign BusyOut  = (state != IDLE);
    assign StallOut = BusyOut & (StartIn | HiLoReadIn);

    // Operand magnitudes, one restoring-divide step, and the sign fixup of the finished result
    always_comb begin
        aNeg     = ~OpIn[0] & AIn[DATA_W-1];
        bNeg     = ~OpIn[0] & BIn[DATA_W-1];
        aMag     = aNeg ? (DATA_W'(0) - AIn) : AIn;
        bMag     = bNeg ? (DATA_W'(0) - BIn) : BIn;
        remShift = {rem, quo[DATA_W-1]};
        trial    = remShift - {1'b0, bReg};
        signDiff = ~opReg[0] & (signA ^ signB);
        divZero  = (bReg == '0);
        prodFix  = signDiff ? (RES_W'(0) - acc) : acc;
        // Divide by zero keeps the all-ones quotient; the remainder (|A|) regains A's sign, giving raw A
        quoFix   = (signDiff & ~divZero) ? (DATA_W'(0) - quo) : quo;
        remFix   = (~opReg[0] & signA) ? (DATA_W'(0) - rem) : rem;
        fixed    = opReg[1] ? {remFix, quoFix} : prodFix;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            count       <= '0;
            opReg       <= '0;
            signA       <= 1'b0;
            signB       <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            bReg        <= '0;
            rem         <= '0;
            quo         <= '0;
            DoneOut     <= 1'b0;
            HiWriteOut  <= 1'b0;
            LoWriteOut  <= 1'b0;
            Result64Out <= '0;
        end else begin
            DoneOut    <= 1'b0;
            HiWriteOut <= 1'b0;
            LoWriteOut <= 1'b0;
            case (state)
                IDLE: begin
                    if (StartIn) begin
                        opReg <= OpIn;
                        signA <= aNeg;
                        signB <= bNeg;
                        count <= '0;
                        acc   <= '0;
                        mcand <= RES_W'(aMag);
                        bReg  <= bMag;
                        rem   <= '0;
                        quo   <= aMag;
                        state <= OpIn[1] ? DIV : MUL;
                    end
                end
                MUL: begin
                    if (bReg[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    bReg  <= bReg >> 1;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(DATA_W - 1)) begin
                        state <= FIX;
                    end
                end
                DIV: begin
                    quo   <= {quo[DATA_W-2:0], ~trial[DATA_W]};
                    rem   <= trial[DATA_W] ? remShift[DATA_W-1:0] : trial[DATA_W-1:0];
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(DATA_W - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Result64Out <= fixed;
                    DoneOut     <= 1'b1;
                    HiWriteOut  <= 1'b1;
                    LoWriteOut  <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: latency, strobes, signed/unsigned results,
// divide-by-zero, overflow, stall behaviour and mid-operation reset.
module tb_hilo_muldiv_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        StartIn;
    logic [1:0]  OpIn;
    logic [31:0] AIn;
    logic [31:0] BIn;
    logic        HiLoReadIn;
    logic        BusyOut;
    logic        StallOut;
    logic        DoneOut;
    logic        HiWriteOut;
    logic        LoWriteOut;
    logic [63:0] Result64Out;

    int total = 0;
    int bad   = 0;

    hilo_muldiv_ctrl #(.DATA_W(32)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .StartIn     (StartIn),
        .OpIn        (OpIn),
        .AIn         (AIn),
        .BIn         (BIn),
        .HiLoReadIn  (HiLoReadIn),
        .BusyOut     (BusyOut),
        .StallOut    (StallOut),
        .DoneOut     (DoneOut),
        .HiWriteOut  (HiWriteOut),
        .LoWriteOut  (LoWriteOut),
        .Result64Out (Result64Out)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Presents an op in the current (idle) cycle as cycle 0 and follows it through cycle 35
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
        int firstDone = -1;
        int nDone = 0;
        int nHi = 0;
        int nLo = 0;
        int nBusy = 0;
        logic [63:0] res = '0;
        StartIn = 1'b1;
        OpIn    = op;
        AIn     = a;
        BIn     = b;
        #1;
        chk({tag, "_busy_c0"}, 64'(BusyOut), 64'd0);
        for (int c = 1; c <= 35; c++) begin
            tick();
            StartIn = 1'b0;
            AIn     = $urandom;
            BIn     = $urandom;
            #1;
            if (DoneOut) begin
                nDone++;
                if (firstDone < 0) firstDone = c;
                res = Result64Out;
            end
            if (HiWriteOut) nHi++;
            if (LoWriteOut) nLo++;
            if (c <= 34 && BusyOut) nBusy++;
        end
        chk({tag, "_done_cycle"}, 64'(firstDone), 64'd34);
        chk({tag, "_done_count"}, 64'(nDone), 64'd1);
        chk({tag, "_hiwrite_count"}, 64'(nHi), 64'd1);
        chk({tag, "_lowrite_count"}, 64'(nLo), 64'd1);
        chk({tag, "_busy_cycles"}, 64'(nBusy), 64'd34);
        chk({tag, "_busy_c35"}, 64'(BusyOut), 64'd0);
        chk({tag, "_result"}, res, exp);
        chk({tag, "_result_hold"}, Result64Out, exp);
    endtask

    initial begin
        int stallErr;
        int doneAt;
        int nDone;
        logic [63:0] res;

        Reset      = 1'b1;
        StartIn    = 1'b0;
        OpIn       = 2'b00;
        AIn        = '0;
        BIn        = '0;
        HiLoReadIn = 1'b0;
        repeat (3) tick();
        #1;
        chk("rst_busy", 64'(BusyOut), 64'd0);
        chk("rst_stall", 64'(StallOut), 64'd0);
        chk("rst_done", 64'(DoneOut), 64'd0);
        chk("rst_hiwrite", 64'(HiWriteOut), 64'd0);
        chk("rst_lowrite", 64'(LoWriteOut), 64'd0);
        chk("rst_result", Result64Out, 64'd0);
        Reset = 1'b0;
        tick();

        runOp("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        runOp("mult_neg",   2'b00, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB);
        runOp("mult_min",   2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        runOp("multu_shift",2'b01, 32'h80000000, 32'h00000002, 64'h00000001_00000000);
        runOp("div_neg",    2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
        runOp("divu_zero",  2'b11, 32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF);
        runOp("div_zero",   2'b10, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF);
        runOp("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        runOp("divu_basic", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E);

        // Stall window, ignored start while busy, and re-presented start at cycle 35
        tick();
        stallErr = 0;
        doneAt = -1;
        res = '0;
        StartIn = 1'b1;
        OpIn = 2'b01;
        AIn = 32'd3;
        BIn = 32'd5;
        HiLoReadIn = 1'b0;
        #1;
        if (StallOut !== 1'b0) stallErr++;
        for (int c = 1; c <= 35; c++) begin
            tick();
            StartIn = (c == 10 || c == 35);
            OpIn = 2'b11;
            AIn = 32'd100;
            BIn = 32'd7;
            HiLoReadIn = (c >= 5);
            #1;
            if (c <= 34 && StallOut !== (c >= 5)) stallErr++;
            if (c == 35) chk("stall_c35", 64'(StallOut), 64'd0);
            if (DoneOut && doneAt < 0) begin
                doneAt = c;
                res = Result64Out;
            end
        end
        chk("stall_window", 64'(stallErr), 64'd0);
        chk("stall_first_done", 64'(doneAt), 64'd34);
        chk("stall_no_capture", res, 64'd15);
        doneAt = -1;
        for (int c = 36; c <= 70; c++) begin
            tick();
            StartIn = 1'b0;
            HiLoReadIn = 1'b0;
            #1;
            if (DoneOut && doneAt < 0) begin
                doneAt = c;
                res = Result64Out;
            end
        end
        chk("restart_done_cycle", 64'(doneAt), 64'd69);
        chk("restart_result", res, 64'h00000002_0000000E);

        // Reset during a divide aborts it without a Done pulse
        tick();
        nDone = 0;
        StartIn = 1'b1;
        OpIn = 2'b10;
        AIn = 32'd100;
        BIn = 32'd7;
        #1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            StartIn = 1'b0;
            Reset = (c == 10);
            #1;
            if (c == 10) chk("abort_busy_c10", 64'(BusyOut), 64'd1);
            if (c == 11) begin
                chk("abort_busy_c11", 64'(BusyOut), 64'd0);
                chk("abort_result_c11", Result64Out, 64'd0);
            end
            if (DoneOut) nDone++;
        end
        chk("abort_no_done", 64'(nDone), 64'd0);
        Reset = 1'b0;

        runOp("after_abort", 2'b10, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
